// File: rtl/enemy_pkg.sv
// Shared types and helpers for the enemy march controller: slot record,
// LFSR feedback taps, default sizes and the free-slot priority encoder.
package enemy_pkg;

   typedef struct packed {
      logic       active;
      logic [3:0] col;
      logic [3:0] row;
   } enemy_t;

   // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   localparam int DEF_NUM_ENEMIES = 8;
   localparam int DEF_COLS        = 16;
   localparam int DEF_ROWS        = 12;

   // Returns {found, index} of the lowest clear bit in occ.
   // Callers mark slots that do not exist as occupied.
   function automatic logic [4:0] first_free(input logic [15:0] occ);
      logic [4:0] res;
      res = 5'b0;
      for (int i = 15; i >= 0; i--) begin
         if (!occ[i]) res = {1'b1, 4'(i)};
      end
      return res;
   endfunction

endpackage

// File: rtl/enemy_march_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR that steps once per enabled cycle; reloads SEED on reset.
module lfsr8
   import enemy_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [7:0] state
);

   logic [7:0] state_q;
   logic [7:0] state_d;

   always_comb begin
      state_d = state_q;
      if (en) state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= SEED;
      else       state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/enemy_march_ctrl.sv
// Enemy slot table: spawns on row 0 at a pseudo-random column, marches rows
// down on advance, and reports breaches, dropped spawns, kills and levels.
module enemy_march_ctrl
   import enemy_pkg::*;
#(
   parameter int         NUM_ENEMIES  = DEF_NUM_ENEMIES,
   parameter int         COLS         = DEF_COLS,
   parameter int         ROWS         = DEF_ROWS,
   parameter int         LVL_UP_KILLS = 10,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       run,
   input  logic                       ice,
   input  logic                       spawn,
   input  logic                       advance,
   input  logic                       kill_valid,
   input  logic [3:0]                 kill_idx,
   output logic [NUM_ENEMIES-1:0]     enemy_active,
   output logic [4*NUM_ENEMIES-1:0]   enemy_col,
   output logic [4*NUM_ENEMIES-1:0]   enemy_row,
   output logic                       breach,
   output logic                       spawn_drop,
   output logic                       level_up,
   output logic [3:0]                 lvl
);

   localparam int         CW       = $clog2(COLS);
   localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
   localparam logic [7:0] KILL_TH  = 8'(LVL_UP_KILLS);

   enemy_t     tbl_q [NUM_ENEMIES];
   enemy_t     tbl_d [NUM_ENEMIES];
   logic       breach_q, breach_d;
   logic       spawn_drop_q, spawn_drop_d;
   logic       level_up_q, level_up_d;
   logic [7:0] kill_cnt_q, kill_cnt_d;
   logic [3:0] lvl_q, lvl_d;

   logic [7:0]             lfsr;
   logic                   lfsr_unused;
   logic                   accept;
   logic                   kill_hit;
   logic [NUM_ENEMIES-1:0] kill_sel;
   logic [15:0]            occ;
   logic [4:0]             free_slot;
   logic [3:0]             spawn_col;

   lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .state (lfsr)
   );

   // Only the low column bits feed the table
   assign lfsr_unused = ^lfsr;

   always_comb begin
      accept       = run && !ice;
      kill_sel     = '0;
      occ          = '1;
      spawn_col    = 4'(lfsr[CW-1:0]);
      breach_d     = 1'b0;
      spawn_drop_d = 1'b0;
      level_up_d   = 1'b0;
      kill_cnt_d   = kill_cnt_q;
      lvl_d        = lvl_q;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         tbl_d[i]    = tbl_q[i];
         occ[i]      = tbl_q[i].active;
         kill_sel[i] = kill_valid && (kill_idx == 4'(i)) && tbl_q[i].active;
      end
      kill_hit  = |kill_sel;
      // Free slot comes from the mask at cycle start, so a slot vacated by a
      // kill or a breach this cycle is not handed out until the next one.
      free_slot = first_free(occ);

      for (int i = 0; i < NUM_ENEMIES; i++) begin
         if (kill_sel[i]) begin
            tbl_d[i].active = 1'b0;
            tbl_d[i].row    = 4'd0;
         end else if (accept && advance && tbl_q[i].active) begin
            if (tbl_q[i].row == LAST_ROW) begin
               tbl_d[i].active = 1'b0;
               tbl_d[i].row    = 4'd0;
               breach_d        = 1'b1;
            end else begin
               tbl_d[i].row = tbl_q[i].row + 4'd1;
            end
         end
      end

      if (accept && spawn) begin
         if (!free_slot[4]) spawn_drop_d = 1'b1;
         for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (free_slot[4] && free_slot[3:0] == 4'(i)) begin
               tbl_d[i].active = 1'b1;
               tbl_d[i].row    = 4'd0;
               tbl_d[i].col    = spawn_col;
            end
         end
      end

      if (kill_hit) begin
         if (kill_cnt_q + 8'd1 == KILL_TH) begin
            kill_cnt_d = 8'd0;
            level_up_d = 1'b1;
            if (lvl_q != 4'd15) lvl_d = lvl_q + 4'd1;
         end else begin
            kill_cnt_d = kill_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENEMIES; i++) tbl_q[i] <= '0;
         breach_q     <= 1'b0;
         spawn_drop_q <= 1'b0;
         level_up_q   <= 1'b0;
         kill_cnt_q   <= 8'd0;
         lvl_q        <= 4'd0;
      end else begin
         for (int i = 0; i < NUM_ENEMIES; i++) tbl_q[i] <= tbl_d[i];
         breach_q     <= breach_d;
         spawn_drop_q <= spawn_drop_d;
         level_up_q   <= level_up_d;
         kill_cnt_q   <= kill_cnt_d;
         lvl_q        <= lvl_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         enemy_active[i]     = tbl_q[i].active;
         enemy_col[4*i +: 4] = tbl_q[i].col;
         enemy_row[4*i +: 4] = tbl_q[i].row;
      end
   end

   assign breach     = breach_q;
   assign spawn_drop = spawn_drop_q;
   assign level_up   = level_up_q;
   assign lvl        = lvl_q;

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Scoreboard bench for enemy_march_ctrl: a behavioural model predicts each
// cycle's outputs, which are queued and compared after the clock edge.
module tb_enemy_march_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        ice = 1'b0;
   logic        spawn = 1'b0;
   logic        advance = 1'b0;
   logic        kill_valid = 1'b0;
   logic [3:0]  kill_idx = 4'd0;
   logic [7:0]  enemy_active;
   logic [31:0] enemy_col;
   logic [31:0] enemy_row;
   logic        breach;
   logic        spawn_drop;
   logic        level_up;
   logic [3:0]  lvl;

   enemy_march_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .ice          (ice),
      .spawn        (spawn),
      .advance      (advance),
      .kill_valid   (kill_valid),
      .kill_idx     (kill_idx),
      .enemy_active (enemy_active),
      .enemy_col    (enemy_col),
      .enemy_row    (enemy_row),
      .breach       (breach),
      .spawn_drop   (spawn_drop),
      .level_up     (level_up),
      .lvl          (lvl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  act;
      logic [31:0] col;
      logic [31:0] row;
      logic        br;
      logic        dr;
      logic        lu;
      logic [3:0]  lv;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc_no  = 0;

   // Reference state
   logic [7:0] m_act;
   logic [3:0] m_col [8];
   logic [3:0] m_row [8];
   logic [7:0] m_lfsr;
   logic [7:0] m_kcnt;
   logic [3:0] m_lvl;
   logic       m_br, m_dr, m_lu;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc_no, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic model_step();
      logic [7:0] na;
      logic [3:0] nc [8];
      logic [3:0] nr [8];
      int         killed;
      bit         found;
      m_br = 1'b0;
      m_dr = 1'b0;
      m_lu = 1'b0;
      if (reset) begin
         m_act  = 8'd0;
         m_lfsr = 8'hA5;
         m_kcnt = 8'd0;
         m_lvl  = 4'd0;
         for (int i = 0; i < 8; i++) begin
            m_col[i] = 4'd0;
            m_row[i] = 4'd0;
         end
      end else begin
         na = m_act;
         nc = m_col;
         nr = m_row;
         killed = -1;
         if (kill_valid && kill_idx < 4'd8 && m_act[kill_idx[2:0]]) begin
            na[kill_idx[2:0]] = 1'b0;
            nr[kill_idx[2:0]] = 4'd0;
            killed = int'(kill_idx);
         end
         if (run && !ice && advance) begin
            for (int i = 0; i < 8; i++) begin
               if (m_act[i] && i != killed) begin
                  if (m_row[i] == 4'd11) begin
                     na[i] = 1'b0;
                     nr[i] = 4'd0;
                     m_br  = 1'b1;
                  end else begin
                     nr[i] = m_row[i] + 4'd1;
                  end
               end
            end
         end
         if (run && !ice && spawn) begin
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
               if (!found && !m_act[i]) begin
                  found = 1'b1;
                  na[i] = 1'b1;
                  nr[i] = 4'd0;
                  nc[i] = m_lfsr[3:0];
               end
            end
            if (!found) m_dr = 1'b1;
         end
         if (killed >= 0) begin
            if (m_kcnt == 8'd9) begin
               m_kcnt = 8'd0;
               m_lu   = 1'b1;
               if (m_lvl != 4'd15) m_lvl = m_lvl + 4'd1;
            end else begin
               m_kcnt = m_kcnt + 8'd1;
            end
         end
         if (run) m_lfsr = lfsr_next(m_lfsr);
         m_act = na;
         m_col = nc;
         m_row = nr;
      end
   endtask

   // One clock: predict, push, clock, pop and compare
   task automatic cyc();
      exp_t e;
      exp_t g;
      model_step();
      e.act = m_act;
      for (int i = 0; i < 8; i++) begin
         e.col[4*i +: 4] = m_col[i];
         e.row[4*i +: 4] = m_row[i];
      end
      e.br = m_br;
      e.dr = m_dr;
      e.lu = m_lu;
      e.lv = m_lvl;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc_no++;
      g = exp_q.pop_front();
      chk("active", 32'(enemy_active), 32'(g.act));
      chk("col", enemy_col, g.col);
      chk("row", enemy_row, g.row);
      chk("breach", 32'(breach), 32'(g.br));
      chk("spawn_drop", 32'(spawn_drop), 32'(g.dr));
      chk("level_up", 32'(level_up), 32'(g.lu));
      chk("lvl", 32'(lvl), 32'(g.lv));
   endtask

   task automatic drive(input logic s, input logic a, input logic kv, input logic [3:0] ki);
      spawn      = s;
      advance    = a;
      kill_valid = kv;
      kill_idx   = ki;
      cyc();
      spawn      = 1'b0;
      advance    = 1'b0;
      kill_valid = 1'b0;
      kill_idx   = 4'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      // 1: reset state, then first spawn lands in slot 0 at seed column
      run = 1'b1;
      do_reset();
      chk("rst_active", 32'(enemy_active), 32'd0);
      chk("rst_lvl", 32'(lvl), 32'd0);
      drive(1, 0, 0, 0);
      chk("t1_active", 32'(enemy_active), 32'h01);
      chk("t1_col", 32'(enemy_col[3:0]), 32'h5);

      // 2: fill all slots, ninth spawn is dropped
      for (int i = 0; i < 7; i++) drive(1, 0, 0, 0);
      chk("t2_full", 32'(enemy_active), 32'hFF);
      drive(1, 0, 0, 0);
      chk("t2_drop", 32'(spawn_drop), 32'd1);
      drive(0, 0, 0, 0);
      chk("t2_drop_end", 32'(spawn_drop), 32'd0);

      // 3: single enemy marches to the bottom and breaches
      do_reset();
      drive(1, 0, 0, 0);
      for (int k = 1; k <= 11; k++) begin
         drive(0, 1, 0, 0);
         chk("t3_row", 32'(enemy_row[3:0]), 32'(k));
         drive(0, 0, 0, 0);
      end
      drive(0, 1, 0, 0);
      chk("t3_breach", 32'(breach), 32'd1);
      chk("t3_cleared", 32'(enemy_active), 32'd0);
      drive(0, 0, 0, 0);
      chk("t3_breach_end", 32'(breach), 32'd0);

      // 4: ice blocks spawn/advance but not kills
      do_reset();
      drive(1, 0, 0, 0);
      ice = 1'b1;
      drive(1, 1, 0, 0);
      drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      chk("t4_frozen_row", 32'(enemy_row[3:0]), 32'd0);
      drive(0, 0, 1, 4'd0);
      chk("t4_kill", 32'(enemy_active), 32'd0);
      ice = 1'b0;
      run = 1'b0;
      drive(1, 1, 0, 0);
      run = 1'b1;

      // 5: kill beats advance on a last-row slot; spawn uses another slot
      do_reset();
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int k = 0; k < 11; k++) drive(0, 1, 0, 0);
      drive(0, 0, 1, 4'd0);
      drive(0, 0, 1, 4'd1);
      drive(1, 1, 1, 4'd2);
      chk("t5_breach", 32'(breach), 32'd0);
      chk("t5_active", 32'(enemy_active), 32'h01);

      // 6: level progression, ignored kills, saturation at 15
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 0, 0);
         if (k == 4) drive(0, 0, 1, 4'd5);
         if (k == 6) drive(0, 0, 1, 4'd12);
         drive(0, 0, 1, 4'd0);
      end
      chk("t6_lvl1", 32'(lvl), 32'd1);
      for (int k = 0; k < 150; k++) begin
         drive(1, 0, 0, 0);
         drive(0, 0, 1, 4'd0);
      end
      chk("t6_lvl15", 32'(lvl), 32'd15);
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 0, 0);
         drive(0, 0, 1, 4'd0);
      end
      chk("t6_sat_pulse", 32'(level_up), 32'd1);
      chk("t6_sat_lvl", 32'(lvl), 32'd15);

      // Reset with every strobe active
      drive(1, 0, 0, 0);
      spawn = 1'b1; advance = 1'b1; kill_valid = 1'b1; kill_idx = 4'd0;
      do_reset();
      spawn = 1'b0; advance = 1'b0; kill_valid = 1'b0;
      chk("midrst_active", 32'(enemy_active), 32'd0);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         run   = ($urandom_range(0, 9) != 0);
         ice   = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 199) == 0);
         drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 9)));
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
